// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: RISC-V execute stage with ALU, branch evaluation and an
// iterative multiply/divide unit, plus the E->M pipeline register.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   *E controls               decode controls for the instruction in E
//   FlushE                    kill the E instruction, abort the MDU
//   ALUControlE/BranchOpE/MulDivOpE  operation selects
//   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW  operands, PCs, W result
//   RD_E, ForwardA_E, ForwardB_E  destination register and forward selects
//   StallE, PCSrcE, PCTargetE combinational hazard/redirect outputs
//   *M outputs                registered E->M state
module execute_stage_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidE,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            MulDivE,
    input  logic            FlushE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      BranchOpE,
    input  logic [2:0]      MulDivOpE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    output logic            StallE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            ValidM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_res;
    logic [SHW-1:0]  shamt;
    logic            br_cond, valid_e, mdu_req;

    // Operand forwarding; select 11 falls back to the register file
    always_comb begin
        fwd_a = RD1_E;
        fwd_b = RD2_E;
        case (ForwardA_E)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALU_ResultM;
            default: fwd_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
    assign shamt = src_b[SHW-1:0];

    // ALU
    always_comb begin
        alu_res = '0;
        case (ALUControlE)
            4'd0:    alu_res = fwd_a + src_b;
            4'd1:    alu_res = fwd_a - src_b;
            4'd2:    alu_res = fwd_a & src_b;
            4'd3:    alu_res = fwd_a | src_b;
            4'd4:    alu_res = fwd_a ^ src_b;
            4'd5:    alu_res = XLEN'($signed(fwd_a) < $signed(src_b));
            4'd6:    alu_res = XLEN'(fwd_a < src_b);
            4'd7:    alu_res = fwd_a << shamt;
            4'd8:    alu_res = fwd_a >> shamt;
            4'd9:    alu_res = XLEN'($signed(fwd_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Branch condition on forwarded operands
    always_comb begin
        br_cond = 1'b0;
        case (BranchOpE)
            3'b000:  br_cond = (fwd_a == fwd_b);
            3'b001:  br_cond = (fwd_a != fwd_b);
            3'b100:  br_cond = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_cond = (fwd_a <  fwd_b);
            3'b111:  br_cond = (fwd_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    // Reset masks the incoming instruction so nothing stalls or redirects
    assign valid_e   = ValidE & ~rst;
    assign mdu_req   = valid_e & MulDivE & ~FlushE;
    assign StallE    = ~rst & (((state_q == IDLE) & mdu_req) | (state_q == BUSY));
    assign PCSrcE    = valid_e & ~FlushE & ~MulDivE & ((BranchE & br_cond) | JumpE);
    assign PCTargetE = PCE + Imm_Ext_E;

    // MDU latched operands and divider state
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, pcp4_q, quo_q, rem_q, dvs_q;
    logic [4:0]      rd_q;
    logic            regw_q;
    logic [CW-1:0]   cnt_q;
    logic            sgn_in;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   rem_sh, rem_diff;
    logic            rem_ok;

    // Division works on magnitudes; signs are restored when the result is taken
    assign sgn_in = MulDivOpE[2] & ~MulDivOpE[0];
    assign mag_a  = (sgn_in & fwd_a[XLEN-1]) ? -fwd_a : fwd_a;
    assign mag_b  = (sgn_in & fwd_b[XLEN-1]) ? -fwd_b : fwd_b;

    // One restoring-division step: shift in the next dividend bit, try subtract
    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign rem_ok   = rem_sh[XLEN] | ~rem_diff[XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
            pcp4_q <= '0;
            regw_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (state_q == IDLE) begin
            if (mdu_req) begin
                op_q   <= MulDivOpE;
                a_q    <= fwd_a;
                b_q    <= fwd_b;
                rd_q   <= RD_E;
                pcp4_q <= PCPlus4E;
                regw_q <= RegWriteE;
                cnt_q  <= MulDivOpE[2] ? CW'(XLEN) : '0;
                quo_q  <= mag_a;
                rem_q  <= '0;
                dvs_q  <= mag_b;
            end
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - CW'(1);
            quo_q <= {quo_q[XLEN-2:0], rem_ok};
            rem_q <= rem_ok ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; flush aborts from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mdu_req) state_d = MulDivOpE[2] ? BUSY : DONE;
            BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (FlushE) state_d = IDLE;
    end

    // MDU result selection, including divide-by-zero and signed overflow
    logic            a_s, b_s, sgn_q;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0] quo_fix, rem_fix, mdu_res;

    assign a_s   = (op_q == 3'b001) | (op_q == 3'b010);
    assign b_s   = (op_q == 3'b001);
    assign a_ext = {{XLEN{a_s & a_q[XLEN-1]}}, a_q};
    assign b_ext = {{XLEN{b_s & b_q[XLEN-1]}}, b_q};
    assign prod  = a_ext * b_ext;
    assign sgn_q = ~op_q[0];

    always_comb begin
        quo_fix = quo_q;
        rem_fix = rem_q;
        if (b_q == '0) begin
            quo_fix = '1;
            rem_fix = a_q;
        end else if (sgn_q & (a_q == SMIN) & (b_q == '1)) begin
            quo_fix = a_q;
            rem_fix = '0;
        end else begin
            if (sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1])) quo_fix = -quo_q;
            if (sgn_q & a_q[XLEN-1])                 rem_fix = -rem_q;
        end
        mdu_res = '0;
        case (op_q)
            3'b000:          mdu_res = prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          mdu_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:  mdu_res = quo_fix;
            default:         mdu_res = rem_fix;
        endcase
    end

    // E->M pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            ValidM      <= 1'b0;
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else if (FlushE || (StallE && state_q != DONE)) begin
            ValidM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else if (state_q == DONE) begin
            ValidM      <= 1'b1;
            RegWriteM   <= regw_q;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= rd_q;
            PCPlus4M    <= pcp4_q;
            WriteDataM  <= b_q;
            ALU_ResultM <= mdu_res;
        end else begin
            ValidM      <= ValidE;
            RegWriteM   <= ValidE & RegWriteE;
            MemWriteM   <= ValidE & MemWriteE;
            ResultSrcM  <= ValidE & ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwd_b;
            ALU_ResultM <= alu_res;
        end
    end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// tb_execute_stage_mdu: directed bench for execute_stage_mdu. Expected M-stage
// results are queued when an instruction is issued; a monitor pops and checks
// them whenever ValidM is seen.
module tb_execute_stage_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, MulDivE, FlushE;
    logic [3:0]  ALUControlE;
    logic [2:0]  BranchOpE, MulDivOpE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        StallE, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ValidM, RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    execute_stage_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .MulDivE(MulDivE), .FlushE(FlushE), .ALUControlE(ALUControlE), .BranchOpE(BranchOpE),
        .MulDivOpE(MulDivOpE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ResultW(ResultW), .RD_E(RD_E), .ForwardA_E(ForwardA_E),
        .ForwardB_E(ForwardB_E), .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [31:0] val, input logic [4:0] rd);
        exp_t e;
        e.name = name;
        e.val  = val;
        e.rd   = rd;
        sb.push_back(e);
    endtask

    // Monitor: every valid M-stage result must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (ValidM === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%08h rd %0d, expected no result", ALU_ResultM, RD_M);
            end else begin
                e = sb.pop_front();
                chk(e.name, ALU_ResultM, e.val);
                chk({e.name, "_rd"}, 32'(RD_M), 32'(e.rd));
            end
        end
    end

    task automatic set_idle();
        ValidE = 0; RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0;
        BranchE = 0; JumpE = 0; MulDivE = 0; FlushE = 0;
        ALUControlE = 0; BranchOpE = 0; MulDivOpE = 0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
        RD_E = 0; ForwardA_E = 0; ForwardB_E = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one MDU op, hold it while StallE is high, then release after DONE
    task automatic run_mdu(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall, input logic [31:0] exp,
                           input logic [4:0] rd, input bit br);
        int stall;
        set_idle();
        ValidE = 1; MulDivE = 1; RegWriteE = 1; MulDivOpE = op;
        RD1_E = a; RD2_E = b; RD_E = rd;
        if (br) begin
            BranchE = 1; JumpE = 1; BranchOpE = 3'b000;
        end
        push(name, exp, rd);
        stall = 0;
        @(negedge clk);
        chk({name, "_pcsrc"}, 32'(PCSrcE), 32'd0);
        while (StallE === 1'b1 && stall < 100) begin
            stall++;
            @(negedge clk);
        end
        chk({name, "_stall_cycles"}, 32'(stall), 32'(exp_stall));
        next_cycle();
        set_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vm;
        set_idle();
        rst = 1;
        ValidE = 1; RegWriteE = 1; ALUSrcE = 1; RD1_E = 1; Imm_Ext_E = 3; RD_E = 5;
        repeat (2) begin
            @(negedge clk);
            chk("rst_validm", 32'(ValidM), 32'd0);
            chk("rst_alu_result", ALU_ResultM, 32'd0);
            chk("rst_stall", 32'(StallE), 32'd0);
        end
        next_cycle();
        rst = 0;
        push("add_1_3", 32'd4, 5'd5);
        next_cycle();
        set_idle();
        @(negedge clk);
        chk("add_validm", 32'(ValidM), 32'd1);
        next_cycle();

        // Forwarding from M feeding an arithmetic shift right
        ValidE = 1; RegWriteE = 1; ALUSrcE = 1; RD1_E = 32'h8000_0000; Imm_Ext_E = 0; RD_E = 6;
        push("add_min", 32'h8000_0000, 5'd6);
        next_cycle();
        ForwardA_E = 2'b10; ALUControlE = 4'd9; Imm_Ext_E = 4; RD1_E = 0; RD_E = 7;
        push("sra_fwd", 32'hF800_0000, 5'd7);
        next_cycle();

        // BLTU taken with B forwarded from W
        set_idle();
        ValidE = 1; RD1_E = 5; RD2_E = 100; ForwardB_E = 2'b01; ResultW = 7;
        BranchE = 1; BranchOpE = 3'b110; PCE = 32'h100; Imm_Ext_E = 32'h40; RD_E = 8;
        push("bltu_alu", 32'd12, 5'd8);
        @(negedge clk);
        chk("bltu_pcsrc", 32'(PCSrcE), 32'd1);
        chk("bltu_target", PCTargetE, 32'h140);
        next_cycle();
        // BGE not taken, forward select 11 reads the register file
        ForwardA_E = 2'b11; BranchOpE = 3'b101;
        push("bge_alu", 32'd12, 5'd8);
        @(negedge clk);
        chk("bge_pcsrc", 32'(PCSrcE), 32'd0);
        next_cycle();
        set_idle();

        run_mdu("mulh",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'h0000_0000, 5'd9,  0);
        run_mdu("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'hFFFF_FFFE, 5'd10, 0);
        run_mdu("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'hFFFF_FFFF, 5'd11, 0);
        run_mdu("mul",      3'b000, 32'd6,         32'd7,         1,  32'd42,        5'd12, 0);
        run_mdu("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD, 5'd13, 0);
        run_mdu("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 5'd14, 0);
        run_mdu("divu_z",   3'b101, 32'd5,         32'd0,         33, 32'hFFFF_FFFF, 5'd15, 0);
        run_mdu("remu_z",   3'b111, 32'd5,         32'd0,         33, 32'd5,         5'd16, 0);
        run_mdu("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         5'd17, 0);
        run_mdu("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 5'd18, 0);
        run_mdu("divu",     3'b101, 32'd100,       32'd7,         33, 32'd14,        5'd19, 0);
        run_mdu("rem_negb", 3'b110, 32'd7,         32'hFFFF_FFFE, 33, 32'd1,         5'd20, 0);

        // Flush in the 10th BUSY cycle: no result may ever appear
        ValidE = 1; MulDivE = 1; RegWriteE = 1; MulDivOpE = 3'b100; RD1_E = 100; RD2_E = 3; RD_E = 21;
        @(negedge clk);
        chk("flush_abort_stall0", 32'(StallE), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        set_idle();
        FlushE = 1;
        next_cycle();
        FlushE = 0;
        @(negedge clk);
        chk("flush_abort_stall", 32'(StallE), 32'd0);
        chk("flush_abort_validm", 32'(ValidM), 32'd0);
        vm = 0;
        repeat (40) begin
            @(negedge clk);
            if (ValidM === 1'b1) vm++;
        end
        chk("flush_abort_noresult", 32'(vm), 32'd0);
        next_cycle();

        // Reset in the 5th BUSY cycle with the instruction still held
        ValidE = 1; MulDivE = 1; RegWriteE = 1; MulDivOpE = 3'b101; RD1_E = 100; RD2_E = 3; RD_E = 22;
        repeat (5) @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk("rst_abort_stall_in_rst", 32'(StallE), 32'd0);
        next_cycle();
        rst = 0;
        set_idle();
        @(negedge clk);
        chk("rst_abort_stall", 32'(StallE), 32'd0);
        chk("rst_abort_validm", 32'(ValidM), 32'd0);
        vm = 0;
        repeat (40) begin
            @(negedge clk);
            if (ValidM === 1'b1) vm++;
        end
        chk("rst_abort_noresult", 32'(vm), 32'd0);
        next_cycle();

        // Flush together with a new DIV: flush wins
        ValidE = 1; MulDivE = 1; RegWriteE = 1; MulDivOpE = 3'b100; RD1_E = 9; RD2_E = 3; RD_E = 23;
        FlushE = 1;
        @(negedge clk);
        chk("flush_new_stall", 32'(StallE), 32'd0);
        next_cycle();
        set_idle();
        @(negedge clk);
        chk("flush_new_validm", 32'(ValidM), 32'd0);
        chk("flush_new_idle", 32'(StallE), 32'd0);
        next_cycle();

        // Branch/jump bits on an MDU instruction never redirect
        run_mdu("mul_branch", 3'b000, 32'd3, 32'd3, 1, 32'd9, 5'd24, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
